// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/stall controller and its mult/div sequencer.
package pipe_stall_ctrl_pkg;

   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic MD_MULT = 1'b0;
   localparam logic MD_DIV  = 1'b1;

   localparam int unsigned MD_CNT_W = 4;

   typedef enum logic {StIdle, StBusy} md_state_e;

   // Source register must wait if a pending writer produces it later than it is needed.
   function automatic logic src_hazard(input logic [4:0] src_addr,
                                       input logic [1:0] src_tuse,
                                       input logic       wr_en,
                                       input logic [4:0] wr_addr,
                                       input logic [1:0] wr_tnew);
      return (src_addr != 5'd0) && wr_en && (wr_addr == src_addr) && (wr_tnew > src_tuse);
   endfunction

endpackage

// File: rtl/pipe_stall_ctrl_md_busy_seq.sv
// Mult/div occupancy sequencer: down-counts the unit latency and flags overlapping starts.
module md_busy_seq
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic op,
   output logic busy,
   output logic done,
   output logic err
);

   localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
   localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);
   localparam logic [MD_CNT_W-1:0] CNT_ONE   = MD_CNT_W'(1);

   md_state_e           state_q, state_d;
   logic [MD_CNT_W-1:0] cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               cnt_d   = (op == MD_DIV) ? DIV_LOAD : MULT_LOAD;
               state_d = StBusy;
            end
         end
         StBusy: begin
            // A start while occupied (including the exit cycle) is dropped and latched as an error.
            if (start) begin
               err_d = 1'b1;
            end
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      done_d = (state_d == StBusy) && (cnt_d == CNT_ONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy = (state_q == StBusy);
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Five-stage pipeline hazard controller: Tuse/Tnew stalls, mult/div occupancy stall, stall counter.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       D_rs_addr,
   input  logic [4:0]       D_rt_addr,
   input  logic [1:0]       D_rs_tuse,
   input  logic [1:0]       D_rt_tuse,
   input  logic             D_is_md,
   input  logic [4:0]       E_reg_addr,
   input  logic             E_reg_write,
   input  logic [1:0]       E_tnew,
   input  logic [4:0]       M_reg_addr,
   input  logic             M_reg_write,
   input  logic [1:0]       M_tnew,
   input  logic             E_md_start,
   input  logic             E_md_op,
   output logic             F_en,
   output logic             D_en,
   output logic             E_clr,
   output logic             md_busy,
   output logic             md_done,
   output logic             md_err,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             stall_rs, stall_rt, stall_md, stall;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   md_busy_seq #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_busy_seq (
      .clk   (clk),
      .reset (reset),
      .start (E_md_start),
      .op    (E_md_op),
      .busy  (md_busy),
      .done  (md_done),
      .err   (md_err)
   );

   always_comb begin
      stall_rs = src_hazard(D_rs_addr, D_rs_tuse, E_reg_write, E_reg_addr, E_tnew) |
                 src_hazard(D_rs_addr, D_rs_tuse, M_reg_write, M_reg_addr, M_tnew);
      stall_rt = src_hazard(D_rt_addr, D_rt_tuse, E_reg_write, E_reg_addr, E_tnew) |
                 src_hazard(D_rt_addr, D_rt_tuse, M_reg_write, M_reg_addr, M_tnew);
      stall_md = D_is_md & (md_busy | E_md_start);
      // Reset forces the pipeline to flow so the front end is not frozen while held in reset.
      stall    = reset & (stall_rs | stall_rt | stall_md);
   end

   assign F_en  = ~stall;
   assign D_en  = ~stall;
   assign E_clr = stall;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Hazard and stall controller for the five-stage pipeline. It drives the enables of the F/D pipeline registers and the bubble-insert clear of the D->E register. It decides from Tuse/Tnew comparison against the E and M stage register writers. It also owns the multi-cycle mult/div busy sequencer and stalls any D-stage HI/LO/md instruction while that unit is occupied.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 2..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 2..15)
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
D_rs_addr  in  5  rs field of the D-stage instruction
D_rt_addr  in  5  rt field of the D-stage instruction
D_rs_tuse  in  2  cycles until D instr needs rs (3 = not used)
D_rt_tuse  in  2  cycles until D instr needs rt (3 = not used)
D_is_md  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
E_reg_addr  in  5  destination register of the E-stage instruction
E_reg_write  in  1  E-stage instruction writes the GPR file
E_tnew  in  2  cycles until the E result is available
M_reg_addr  in  5  destination register of the M-stage instruction
M_reg_write  in  1  M-stage instruction writes the GPR file
M_tnew  in  2  cycles until the M result is available
E_md_start  in  1  E-stage instruction is a valid mult/div this cycle
E_md_op  in  1  0 = mult family, 1 = div family
F_en  out  1  PC / F-register enable
D_en  out  1  D-register (F->D) enable
E_clr  out  1  synchronous clear of the D->E register (bubble)
md_busy  out  1  mult/div unit occupied (registered)
md_done  out  1  one-cycle pulse on the final busy cycle (registered)
md_err  out  1  sticky protocol-error flag (registered)
stall_cnt  out  CNT_W  count of stalled cycles, saturating

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, md_busy=0, md_done=0, md_err=0, stall_cnt=0.
- While reset is asserted, stall is forced to 0, so F_en=1, D_en=1, E_clr=0.
- stall_rs = D_rs_addr!=0 and either:
  - E_reg_write and E_reg_addr==D_rs_addr and E_tnew>D_rs_tuse, or
  - M_reg_write and M_reg_addr==D_rs_addr and M_tnew>D_rs_tuse.
- stall_rt is the same using rt.
- Register $0 never stalls.
- stall_md = D_is_md and (md_busy or E_md_start).
- stall = stall_rs | stall_rt | stall_md.
- Outputs are combinational from stall: F_en=~stall, D_en=~stall, E_clr=stall. No added latency.
- Mult/div FSM:
  - IDLE: on E_md_start, load cnt = E_md_op ? DIV_CYCLES : MULT_CYCLES and go to BUSY; md_busy=1 from the next cycle.
  - BUSY: cnt decrements each cycle. When cnt==1, md_done pulses for that cycle and the next state is IDLE, so md_busy=0 the following cycle.
  - Total md_busy high time is exactly the loaded count.
- E_md_start while BUSY: the start is ignored, the count is unaffected, and md_err sets and stays set until reset. This cannot occur if stall_md is honoured.
- E_md_start on the same cycle BUSY exits (cnt==1): treated as busy, so the start is ignored and md_err sets.
- stall_cnt increments by 1 on every rising edge where stall=1. It saturates at all-ones and does not wrap.
- Reset asserted mid-BUSY: the FSM aborts immediately to IDLE with no md_done pulse.

Decomposition:
- Shared package: Tuse/Tnew encodings (TUSE_NONE=3), the MD_MULT/MD_DIV opcode constants, and the FSM state encoding IDLE/BUSY.
- One natural sub-module: md_busy_seq (FSM, down-counter, md_done, md_err).
- The hazard comparators and stall_cnt stay in the top.

Test Plan:
- E_reg_write=1, E_reg_addr=8, E_tnew=2, D_rs_addr=8, D_rs_tuse=0 -> F_en=0, D_en=0, E_clr=1 the same cycle; stall_cnt +1 per edge.
- Same scenario but D_rs_addr=0 (both writer addr and rs =0), or M_tnew=0 with a match -> no stall, F_en=1, E_clr=0.
- E_md_start=1, E_md_op=0 for one cycle:
  - md_busy high for exactly 5 cycles; md_done pulses on the 5th.
  - D_is_md=1 stalls during the start cycle and all 5 busy cycles, then releases.
- E_md_op=1 start -> md_busy high for exactly 10 cycles; a second E_md_start at busy cycle 4 -> md_err=1 sticky, busy still ends at cycle 10.
- Reset pulled low at busy cycle 3 of a div -> md_busy=0 asynchronously, no md_done, stall_cnt=0, F_en=1 while in reset.
- stall held continuously with stall_cnt preloaded to all-ones via a bench parameter CNT_W=4 -> counter holds 15 and does not wrap.
